wb_load_queue: RTL and testbench

Parametrised write-back stage for the five-stage core with decoupled load completion. ALU results and late-arriving load responses are merged onto the single register-file write port. Loads are aligned and sign/zero-extended, then buffered in a small in-order queue whenever the port is taken by an ALU result. Younger ALU writes kill stale queued loads to the same `rd`. The block sits between the LSU and the register file, and drives the write port through registered outputs.

---
 rtl/wb_load_queue.sv | 150 +++++++++++++++
 tb/tb_wb_load_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_load_queue.sv
// Write-back merge of ALU results and aligned load responses onto one register-file port.
// Optional `WB_LQ_BYPASS_EN`: a live load skips the queue when it is empty and the port is free.
module wb_load_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [XLEN-1:0]           alu_out,
    input  logic                      alu_vld,
    input  logic [RD_W-1:0]           alu_rd,
    input  logic                      alu_rd_wen,
    input  logic [XLEN-1:0]           ld_rdata,
    input  logic                      ld_vld,
    input  logic [XLEN/8-1:0]         ld_rstrb,
    input  logic [RD_W-1:0]           ld_rd,
    input  logic                      ld_rd_wen,
    input  logic                      ld_lsign,
    output logic                      ld_rdy,
    output logic [RD_W-1:0]           wb_rd,
    output logic [XLEN-1:0]           wb_rd_data,
    output logic                      wb_rd_wen,
    output logic [$clog2(DEPTH):0]    lq_count,
    output logic [(1<<RD_W)-1:0]      lq_rd_busy
);
    localparam int NB = XLEN / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << RD_W;

    typedef struct packed {
        logic            vld;
        logic            live;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } lq_entry_t;

    // Natural 1/2/4-byte strobes are shifted down and extended; anything else passes raw.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] w,
                                              input logic [NB-1:0]   s,
                                              input logic            sg);
        int              lo;
        int              n;
        logic [NB-1:0]   m;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] keep;
        logic            sbit;
        lo   = 0;
        n    = 0;
        m    = '0;
        sbit = 1'b0;
        keep = '0;
        for (int i = NB - 1; i >= 0; i--)
            if (s[i]) lo = i;
        for (int i = 0; i < NB; i++)
            if (s[i]) n++;
        for (int i = 0; i < NB; i++)
            if (i >= lo && i < lo + n) m[i] = 1'b1;
        align = w;
        if (s != '0 && s != '1 && m == s && (n == 1 || n == 2 || n == 4) && (lo % n) == 0) begin
            sh = w >> (8 * lo);
            for (int b = 0; b < XLEN; b++) begin
                keep[b] = (b < 8 * n);
                if (b == 8 * n - 1) sbit = sh[b];
            end
            align = (sh & keep) | ((sg && sbit) ? ~keep : '0);
        end
    endfunction

    lq_entry_t       q   [DEPTH];
    lq_entry_t       q_n [DEPTH];
    logic [PW-1:0]   head, tail, head_n, tail_n;
    logic [CW-1:0]   occ, occ_n, cnt_n;
    logic [NR-1:0]   busy_n;
    logic [XLEN-1:0] ld_data;
    logic            alu_take, ld_live, ld_dead, byp, deq, enq;

    assign ld_data = align(ld_rdata, ld_rstrb, ld_lsign);

    always_comb begin
        alu_take = alu_vld & alu_rd_wen & (alu_rd != '0);
        ld_live  = ld_vld & ld_rdy & ld_rd_wen & (ld_rd != '0);
        ld_dead  = alu_take & (ld_rd == alu_rd);
`ifdef WB_LQ_BYPASS_EN
        byp      = ld_live & ~alu_take & (occ == '0);
`else
        byp      = 1'b0;
`endif
        deq      = ~alu_take & (occ != '0);
        enq      = ld_live & ~byp;

        q_n = q;
        for (int i = 0; i < DEPTH; i++)
            if (alu_take && q[i].rd == alu_rd) q_n[i].live = 1'b0;
        if (deq) q_n[head].vld = 1'b0;
        // An older load landing with a younger ALU write to the same rd is dead on arrival.
        if (enq) q_n[tail] = '{vld: 1'b1, live: ~ld_dead, rd: ld_rd, data: ld_data};

        head_n = head + PW'(deq);
        tail_n = tail + PW'(enq);
        occ_n  = occ + CW'(enq) - CW'(deq);

        busy_n = '0;
        cnt_n  = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_n[i].vld && q_n[i].live) begin
                busy_n[q_n[i].rd] = 1'b1;
                cnt_n = cnt_n + CW'(1);
            end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            ld_rdy     <= 1'b1;
            wb_rd      <= '0;
            wb_rd_data <= '0;
            wb_rd_wen  <= 1'b0;
            lq_count   <= '0;
            lq_rd_busy <= '0;
        end else begin
            q          <= q_n;
            head       <= head_n;
            tail       <= tail_n;
            occ        <= occ_n;
            ld_rdy     <= (occ_n < CW'(DEPTH));
            lq_count   <= cnt_n;
            lq_rd_busy <= busy_n;
            if (alu_take) begin
                wb_rd      <= alu_rd;
                wb_rd_data <= alu_out;
                wb_rd_wen  <= 1'b1;
            end else if (deq) begin
                wb_rd      <= q[head].rd;
                wb_rd_data <= q[head].data;
                wb_rd_wen  <= q[head].live;
            end else if (byp) begin
                wb_rd      <= ld_rd;
                wb_rd_data <= ld_data;
                wb_rd_wen  <= 1'b1;
            end else begin
                wb_rd_wen  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_load_queue.sv
// Directed bench for wb_load_queue (default build, no bypass).
module tb_wb_load_queue;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic [31:0] alu_out;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic        alu_rd_wen;
    logic [31:0] ld_rdata;
    logic        ld_vld;
    logic [3:0]  ld_rstrb;
    logic [4:0]  ld_rd;
    logic        ld_rd_wen;
    logic        ld_lsign;
    logic        ld_rdy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        wb_rd_wen;
    logic [2:0]  lq_count;
    logic [31:0] lq_rd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_load_queue #(.XLEN(32), .DEPTH(4), .RD_W(5)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .alu_out(alu_out), .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_rd_wen(alu_rd_wen),
        .ld_rdata(ld_rdata), .ld_vld(ld_vld), .ld_rstrb(ld_rstrb), .ld_rd(ld_rd),
        .ld_rd_wen(ld_rd_wen), .ld_lsign(ld_lsign), .ld_rdy(ld_rdy),
        .wb_rd(wb_rd), .wb_rd_data(wb_rd_data), .wb_rd_wen(wb_rd_wen),
        .lq_count(lq_count), .lq_rd_busy(lq_rd_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        alu_vld = 0; alu_rd = 0; alu_rd_wen = 0; alu_out = 0;
        ld_vld = 0; ld_rd = 0; ld_rd_wen = 0; ld_rdata = 0; ld_rstrb = 0; ld_lsign = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_vld = 1; alu_rd_wen = 1; alu_rd = rd; alu_out = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d, input logic [3:0] s, input logic sg);
        ld_vld = 1; ld_rd_wen = 1; ld_rd = rd; ld_rdata = d; ld_rstrb = s; ld_lsign = sg;
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".wen"}, 64'(wb_rd_wen), 64'd1);
        chk({tag, ".rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, ".data"}, 64'(wb_rd_data), 64'(d));
    endtask

    initial begin
        idle();
        RSTN = 0;
        #12;
        chk("rst.wen", 64'(wb_rd_wen), 64'd0);
        chk("rst.rd", 64'(wb_rd), 64'd0);
        chk("rst.data", 64'(wb_rd_data), 64'd0);
        chk("rst.rdy", 64'(ld_rdy), 64'd1);
        chk("rst.cnt", 64'(lq_count), 64'd0);
        chk("rst.busy", 64'(lq_rd_busy), 64'd0);
        RSTN = 1;
        tick();

        // Signed / unsigned byte, halfword, and misaligned strobe: 2-cycle latency
        ld(5, 32'h8000_FF00, 4'b0010, 1); tick(); idle();
        chk("lb.s.cnt", 64'(lq_count), 64'd1);
        chk("lb.s.busy5", 64'(lq_rd_busy[5]), 64'd1);
        chk("lb.s.early", 64'(wb_rd_wen), 64'd0);
        tick(); chk_wb("lb.s", 5, 32'hFFFF_FFFF);
        chk("lb.s.cnt0", 64'(lq_count), 64'd0);
        ld(5, 32'h8000_FF00, 4'b0010, 0); tick(); idle(); tick();
        chk_wb("lb.u", 5, 32'h0000_00FF);
        ld(6, 32'hABCD_0000, 4'b1100, 1); tick(); idle(); tick();
        chk_wb("lh.s", 6, 32'hFFFF_ABCD);
        ld(6, 32'hDEAD_BEEF, 4'b0110, 1); tick(); idle(); tick();
        chk_wb("mis", 6, 32'hDEAD_BEEF);
        tick();
        chk("idle.wen", 64'(wb_rd_wen), 64'd0);

        // Four loads under six ALU writes; queue fills, an overflow load is ignored
        for (int k = 0; k < 6; k++) begin
            idle();
            alu(5'(10 + k), 32'h100 + k);
            if (k < 4) ld(5'(1 + k), 32'h1000 + k, 4'b1111, 0);
            if (k == 4) ld(20, 32'hBAD, 4'b1111, 0);
            tick();
            chk_wb($sformatf("alu%0d", k), 5'(10 + k), 32'h100 + k);
            if (k == 3) begin
                chk("full.rdy", 64'(ld_rdy), 64'd0);
                chk("full.cnt", 64'(lq_count), 64'd4);
                chk("full.busy", 64'(lq_rd_busy), 64'h1E);
            end
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_wb($sformatf("drain%0d", k), 5'(1 + k), 32'h1000 + k);
            if (k == 0) chk("drain.rdy", 64'(ld_rdy), 64'd1);
        end
        tick();
        chk("ovf.nowrite", 64'(wb_rd_wen), 64'd0);
        chk("ovf.cnt", 64'(lq_count), 64'd0);
        chk("ovf.busy", 64'(lq_rd_busy), 64'd0);

        // Younger ALU write kills a queued load
        ld(7, 32'h7777, 4'b1111, 0); tick(); idle();
        chk("kill.busy7", 64'(lq_rd_busy[7]), 64'd1);
        alu(7, 32'h1234); tick(); idle();
        chk_wb("kill.alu", 7, 32'h1234);
        chk("kill.busy7c", 64'(lq_rd_busy[7]), 64'd0);
        chk("kill.cnt", 64'(lq_count), 64'd0);
        chk("kill.rdy", 64'(ld_rdy), 64'd1);
        tick();
        chk("kill.dead", 64'(wb_rd_wen), 64'd0);
        tick();
        chk("kill.idle", 64'(wb_rd_wen), 64'd0);

        // Same-cycle load and ALU to rd 9
        alu(9, 32'h9999); ld(9, 32'h5555, 4'b1111, 0); tick(); idle();
        chk_wb("same.alu", 9, 32'h9999);
        chk("same.cnt", 64'(lq_count), 64'd0);
        chk("same.busy", 64'(lq_rd_busy), 64'd0);
        tick();
        chk("same.dead", 64'(wb_rd_wen), 64'd0);

        // x0 suppression
        alu(0, 32'hAAAA); ld(0, 32'hBBBB, 4'b1111, 0); tick(); idle();
        chk("x0.wen", 64'(wb_rd_wen), 64'd0);
        chk("x0.cnt", 64'(lq_count), 64'd0);
        tick();
        chk("x0.wen2", 64'(wb_rd_wen), 64'd0);
        chk("x0.rdy", 64'(ld_rdy), 64'd1);

        // Reset with three queued entries
        for (int k = 0; k < 3; k++) begin
            alu(20, 32'h2000 + k); ld(5'(21 + k), 32'h3000 + k, 4'b1111, 0); tick();
        end
        chk("pre.cnt", 64'(lq_count), 64'd3);
        idle();
        #2 RSTN = 0;
        #1;
        chk("mrst.wen", 64'(wb_rd_wen), 64'd0);
        chk("mrst.rd", 64'(wb_rd), 64'd0);
        chk("mrst.data", 64'(wb_rd_data), 64'd0);
        chk("mrst.rdy", 64'(ld_rdy), 64'd1);
        chk("mrst.cnt", 64'(lq_count), 64'd0);
        chk("mrst.busy", 64'(lq_rd_busy), 64'd0);
        #2 RSTN = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post%0d.wen", k), 64'(wb_rd_wen), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
